pitch_scorer: RTL and testbench
===============================

Name: pitch_scorer

Overview:
- Producer side of the score/score_ready interface consumed by the running-average tally.
- Compares each detected spectral peak bin from the FFT peak detector against the target note bin.
- Averages absolute bin error over a fixed window of peaks and maps the mean error to a 4-bit score (15 = perfect, 0 = worst).
- Emits one score per window as a single-cycle score_ready pulse; emits a silence penalty score when peaks stop arriving.

Parameters:
- BIN_W, 10, width of peak_bin and target_bin.
- WIN_LOG2, 3, window length is 2^WIN_LOG2 peaks.
- TIMEOUT_CYC, 1000000, clk cycles without peak_valid in ACCUM before a silence score is emitted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  scoring enabled; low forces IDLE.
- target_bin  input  BIN_W  expected peak bin for the current note.
- peak_valid  input  1  one-cycle strobe; peak_bin is valid this cycle.
- peak_bin  input  BIN_W  detected dominant bin.
- score  output  4  last computed score; held between windows.
- score_ready  output  1  one-cycle pulse; score is valid in the same cycle.
- dropped_peaks  output  8  saturating count of peaks ignored in SCORE/EMIT.

Behaviour:
- Reset (async, immediate): state=IDLE; score=0; score_ready=0; dropped_peaks=0; sum, sample count, timeout counter and target register cleared.
- States: IDLE, ACCUM, SCORE, EMIT.
- IDLE: when enable=1, latch target_bin, clear sum/count/timeout, go to ACCUM. peak_valid in IDLE is ignored and not counted as dropped.
- enable=0 in any state: go to IDLE next edge. No score_ready is emitted and the partial window is discarded.
- ACCUM, on peak_valid: err = |peak_bin - target_reg|, saturated to 15 (4 bits); sum += err; count += 1; timeout counter cleared. Sum width is WIN_LOG2+4 bits and cannot overflow.
- ACCUM, window complete: on the edge where count reaches 2^WIN_LOG2, go to SCORE.
- ACCUM, silence: the timeout counter increments on every cycle without peak_valid. On reaching TIMEOUT_CYC, set a silence flag and go to SCORE. The silence score is 0.
- SCORE, one cycle: mean = sum >> WIN_LOG2, truncating; score = 15 - mean, or 0 if the silence flag is set. Go to EMIT.
- EMIT, one cycle: score_ready=1. Clear sum, count, timeout and silence flag; go to ACCUM.
- Latency: with the final window peak_valid in cycle k, score_ready is high in cycle k+2, with the new score on the same cycle. score holds its value until the next EMIT.
- peak_valid during SCORE or EMIT: the peak is ignored; dropped_peaks increments and saturates at 255.
- Target change in ACCUM: if target_bin differs from target_reg, latch the new target and clear sum, count and timeout. If peak_valid arrives in the same cycle, that peak is scored against the new target and counts as sample 1 of the new window.
- Target change in SCORE/EMIT: latched on the return to ACCUM. The in-flight score is unaffected.
- Peak equal to target gives err 0. Peaks above or below the target are symmetric.
- score_ready is never high on two consecutive cycles.

Test Plan:
- WIN_LOG2=2, target=40, peaks 40,41,39,40 -> sum=2, mean=0, score=15; score_ready exactly 2 cycles after the 4th peak, for 1 cycle.
- target=40, peaks 50,50,50,50 -> err=10 each, mean=10, score=5. Then peaks 60,20,100,0 -> all saturate to 15, score=0.
- TIMEOUT_CYC=100, target=40, one peak 40 then no peaks -> score=0 with score_ready 102 cycles after the peak (100 cycles to timeout, then SCORE, then EMIT); the next window starts empty.
- Two peaks at target 40, then target changes to 60 together with peak 60, then peaks 60,61,62 -> only the last four peaks are scored: errors 0,0,1,2, sum 3, mean 0, score=15.
- peak_valid asserted in the SCORE and EMIT cycles -> dropped_peaks=2 and the next window is unaffected. 300 such drops -> dropped_peaks=255.
- Async reset asserted mid-ACCUM between clock edges -> outputs go to 0 immediately. enable low mid-window -> no score_ready; after re-enable, a full 4-peak window is needed before a score appears.

Source files
------------

// File: rtl/pitch_scorer.sv
// pitch_scorer
//   Scores pitch accuracy. Each detected spectral peak bin is compared with
//   the target note bin. The absolute bin error is saturated to 4 bits and
//   averaged over a window of 2^WIN_LOG2 peaks. The mean error maps to a
//   score of 15 - mean, so 15 is perfect. One score is produced per window.
//   A silence score of 0 is produced when peaks stop arriving for
//   TIMEOUT_CYC cycles.
//
// Ports
//   clk_i           system clock, rising edge
//   reset_i         asynchronous, active-high reset
//   enable_i        scoring enabled; low returns to IDLE and drops the window
//   target_bin_i    expected peak bin for the current note
//   peak_valid_i    one-cycle strobe qualifying peak_bin_i
//   peak_bin_i      detected dominant bin
//   score_o         last computed score, held between windows
//   score_ready_o   one-cycle pulse, score_o valid in the same cycle
//   dropped_peaks_o saturating count of peaks that arrived during SCORE/EMIT
//
// State  | meaning
// IDLE   | disabled; waits for enable, then latches target
// ACCUM  | accumulating peak errors; watches for window end or silence
// SCORE  | converts mean error (or silence) into the score
// EMIT   | presents score_ready, clears the window

module pitch_scorer #(
   parameter int BIN_W       = 10,
   parameter int WIN_LOG2    = 3,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic [BIN_W-1:0] target_bin_i,
   input  logic             peak_valid_i,
   input  logic [BIN_W-1:0] peak_bin_i,
   output logic [3:0]       score_o,
   output logic             score_ready_o,
   output logic [7:0]       dropped_peaks_o
);

   localparam int SUM_W = WIN_LOG2 + 4;
   localparam int CNT_W = WIN_LOG2 + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] WIN_LEN  = CNT_W'(1 << WIN_LOG2);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_SCORE = 2'd2,
      S_EMIT  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [BIN_W-1:0]  target_q, target_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              silence_q, silence_d;
   logic [3:0]        score_q, score_d;
   logic [7:0]        dropped_q, dropped_d;

   logic [BIN_W-1:0]  abs_diff;
   logic [3:0]        err;
   logic              restart;
   logic [SUM_W-1:0]  sum_base;
   logic [CNT_W-1:0]  cnt_base;
   logic [CNT_W-1:0]  cnt_inc;
   logic [3:0]        mean;

   // Peaks are always measured against the live target input. When it
   // matches target_q this is the same thing; when it differs, the window
   // restarts and the peak belongs to the new target anyway.
   always_comb begin
      if (peak_bin_i >= target_bin_i)
         abs_diff = peak_bin_i - target_bin_i;
      else
         abs_diff = target_bin_i - peak_bin_i;
      err = (abs_diff > BIN_W'(15)) ? 4'd15 : abs_diff[3:0];
   end

   assign restart  = (target_bin_i != target_q);
   assign sum_base = restart ? '0 : sum_q;
   assign cnt_base = restart ? '0 : cnt_q;
   assign cnt_inc  = cnt_base + CNT_W'(1);
   assign mean     = 4'(sum_q >> WIN_LOG2);

   // State register and datapath registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         target_q  <= '0;
         sum_q     <= '0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         silence_q <= 1'b0;
         score_q   <= '0;
         dropped_q <= '0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         silence_q <= silence_d;
         score_q   <= score_d;
         dropped_q <= dropped_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      silence_d = silence_q;
      score_d   = score_q;
      dropped_d = dropped_q;

      if (peak_valid_i && (state_q == S_SCORE || state_q == S_EMIT) &&
          dropped_q != 8'hFF)
         dropped_d = dropped_q + 8'd1;

      if (!enable_i) begin
         state_d   = S_IDLE;
         silence_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               target_d  = target_bin_i;
               sum_d     = '0;
               cnt_d     = '0;
               tmo_d     = '0;
               silence_d = 1'b0;
               state_d   = S_ACCUM;
            end
            S_ACCUM: begin
               target_d = target_bin_i;
               if (peak_valid_i) begin
                  sum_d = sum_base + SUM_W'(err);
                  cnt_d = cnt_inc;
                  tmo_d = '0;
                  if (cnt_inc == WIN_LEN)
                     state_d = S_SCORE;
               end else if (restart) begin
                  sum_d = '0;
                  cnt_d = '0;
                  tmo_d = '0;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
                  if (tmo_q == TMO_LAST) begin
                     silence_d = 1'b1;
                     state_d   = S_SCORE;
                  end
               end
            end
            S_SCORE: begin
               score_d = silence_q ? 4'd0 : (4'd15 - mean);
               state_d = S_EMIT;
            end
            S_EMIT: begin
               sum_d     = '0;
               cnt_d     = '0;
               tmo_d     = '0;
               silence_d = 1'b0;
               state_d   = S_ACCUM;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs
   always_comb begin
      score_ready_o = (state_q == S_EMIT);
   end

   assign score_o         = score_q;
   assign dropped_peaks_o = dropped_q;

endmodule

// File: tb/tb_pitch_scorer.sv
// Bench for pitch_scorer with a 4-peak window and a 100-cycle silence timeout.
module tb_pitch_scorer;

   localparam int BW = 10;
   localparam int WL = 2;
   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic [BW-1:0] target_bin = '0;
   logic          peak_valid = 1'b0;
   logic [BW-1:0] peak_bin = '0;
   logic [3:0]    score;
   logic          score_ready;
   logic [7:0]    dropped;

   int total = 0;
   int bad = 0;
   int exp_drop = 0;

   pitch_scorer #(.BIN_W(BW), .WIN_LOG2(WL), .TIMEOUT_CYC(TO)) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .enable_i        (enable),
      .target_bin_i    (target_bin),
      .peak_valid_i    (peak_valid),
      .peak_bin_i      (peak_bin),
      .score_o         (score),
      .score_ready_o   (score_ready),
      .dropped_peaks_o (dropped)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [BW-1:0]        tgt;
      logic [3:0][BW-1:0]   p;
      logic [3:0]           exp;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Drive one cycle; returns #1 after the edge so outputs are settled.
   task automatic step(input logic pv, input logic [BW-1:0] pb);
      peak_valid = pv;
      peak_bin   = pb;
      @(posedge clk);
      #1;
      peak_valid = 1'b0;
   endtask

   // Expected score from first principles: saturated absolute errors,
   // truncated mean, inverted onto 0..15.
   function automatic logic [3:0] ref_score(input int t, input int p [4]);
      int s = 0;
      for (int i = 0; i < 4; i++) begin
         int d = p[i] - t;
         if (d < 0) d = -d;
         if (d > 15) d = 15;
         s += d;
      end
      return 4'(15 - s / 4);
   endfunction

   // Sends four peaks (gap idle cycles between them), optionally injects
   // peaks in the SCORE and EMIT cycles, and checks the pulse timing.
   task automatic run_window(input string nm, input int p [4], input int gap,
                             input logic drop, input logic [3:0] exp);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, BW'(p[i]));
         chk({nm, "_early"}, 32'(score_ready), 0);
         if (i < 3)
            for (int g = 0; g < gap; g++) begin
               step(1'b0, '0);
               chk({nm, "_early"}, 32'(score_ready), 0);
            end
      end
      step(drop, BW'(p[0]));
      chk({nm, "_ready"}, 32'(score_ready), 1);
      chk({nm, "_score"}, 32'(score), 32'(exp));
      step(drop, BW'(p[1]));
      chk({nm, "_pulse1"}, 32'(score_ready), 0);
      chk({nm, "_hold"}, 32'(score), 32'(exp));
      if (drop) begin
         exp_drop = (exp_drop + 2 > 255) ? 255 : exp_drop + 2;
         chk({nm, "_dropped"}, 32'(dropped), 32'(exp_drop));
      end
   endtask

   initial begin
      int pk [4];
      int n;
      int t;

      vecs[0] = '{tgt: 10'd40,   p: {10'd40, 10'd39, 10'd41, 10'd40},   exp: 4'd15};
      vecs[1] = '{tgt: 10'd40,   p: {10'd50, 10'd50, 10'd50, 10'd50},   exp: 4'd5};
      vecs[2] = '{tgt: 10'd40,   p: {10'd0, 10'd100, 10'd20, 10'd60},   exp: 4'd0};
      vecs[3] = '{tgt: 10'd40,   p: {10'd40, 10'd40, 10'd40, 10'd40},   exp: 4'd15};
      vecs[4] = '{tgt: 10'd40,   p: {10'd33, 10'd47, 10'd25, 10'd55},   exp: 4'd4};
      vecs[5] = '{tgt: 10'd0,    p: {10'd4, 10'd3, 10'd3, 10'd3},       exp: 4'd12};
      vecs[6] = '{tgt: 10'd1023, p: {10'd1000, 10'd1008, 10'd1020, 10'd1023}, exp: 4'd7};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_score", 32'(score), 0);
      chk("rst_ready", 32'(score_ready), 0);
      chk("rst_dropped", 32'(dropped), 0);
      reset = 1'b0;
      enable = 1'b1;
      target_bin = 10'd40;
      step(1'b0, '0);

      // Table of windows
      for (int v = 0; v < 7; v++) begin
         target_bin = vecs[v].tgt;
         for (int i = 0; i < 4; i++) pk[i] = int'(vecs[v].p[i]);
         run_window($sformatf("vec%0d", v), pk, v % 2, 1'b0, vecs[v].exp);
      end

      // Silence timeout: one peak, then nothing
      target_bin = 10'd40;
      step(1'b1, 10'd40);
      n = 1;
      while (!score_ready && n < 300) begin
         step(1'b0, '0);
         n++;
      end
      chk("tmo_latency", 32'(n), 102);
      chk("tmo_score", 32'(score), 0);
      step(1'b0, '0);
      pk = '{50, 50, 50, 50};
      run_window("tmo_next", pk, 2, 1'b0, 4'd5);

      // Target change together with a peak restarts the window
      target_bin = 10'd40;
      step(1'b1, 10'd40);
      chk("tchg_early", 32'(score_ready), 0);
      step(1'b1, 10'd40);
      chk("tchg_early", 32'(score_ready), 0);
      target_bin = 10'd60;
      pk = '{60, 60, 61, 62};
      run_window("tchg", pk, 0, 1'b0, 4'd15);

      // Peaks in SCORE and EMIT are dropped; the next window is clean
      pk = '{60, 70, 60, 70};
      run_window("drop", pk, 0, 1'b1, 4'd10);
      pk = '{55, 65, 60, 60};
      run_window("drop_next", pk, 0, 1'b0, 4'd13);

      // Random windows, each dropping two peaks; the count saturates
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(3, 0) == 0 || it == 0)
            target_bin = BW'($urandom_range(1000, 20));
         t = int'(target_bin);
         for (int i = 0; i < 4; i++) pk[i] = t + int'($urandom_range(40, 0)) - 20;
         run_window($sformatf("rnd%0d", it), pk, int'($urandom_range(2, 0)), 1'b1,
                    ref_score(t, pk));
      end
      chk("drop_sat", 32'(dropped), 255);

      // enable low mid-window discards the partial window
      target_bin = 10'd40;
      step(1'b1, 10'd45);
      step(1'b1, 10'd45);
      enable = 1'b0;
      step(1'b0, '0);
      chk("dis_ready", 32'(score_ready), 0);
      step(1'b1, 10'd40);
      chk("dis_ready", 32'(score_ready), 0);
      chk("dis_dropped", 32'(dropped), 255);
      enable = 1'b1;
      step(1'b0, '0);
      pk = '{40, 40, 41, 41};
      run_window("reen", pk, 2, 1'b0, 4'd15);
      pk = '{43, 43, 43, 46};
      run_window("pre_rst", pk, 0, 1'b0, 4'd12);

      // Asynchronous reset between edges mid-ACCUM
      step(1'b1, 10'd40);
      step(1'b1, 10'd40);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_score", 32'(score), 0);
      chk("arst_ready", 32'(score_ready), 0);
      chk("arst_dropped", 32'(dropped), 0);
      exp_drop = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0, '0);
      pk = '{40, 50, 40, 50};
      run_window("post_rst", pk, 1, 1'b0, 4'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
